// File: rtl/knap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knap_pkg                                                             |
// | Shared knapsack types, default thresholds and table-access helper.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package knap_pkg;

  localparam int c_N_ITEMS    = 5;
  localparam int c_IW         = 4;
  localparam int c_SW         = 7;
  localparam int c_MIN_VALUE  = 15;
  localparam int c_MAX_WEIGHT = 16;

  // Helper works on a zero-extended table so any legal N_ITEMS*IW fits.
  localparam int c_TBL_MAX_W  = 64;
  localparam int c_ITEM_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } knap_state_e;

  function automatic logic [c_ITEM_MAX_W-1:0] get_item(
    input logic [c_TBL_MAX_W-1:0] tbl,
    input int                     idx,
    input int                     iw
  );
    logic [c_TBL_MAX_W-1:0] shifted;
    logic [c_TBL_MAX_W-1:0] mask;
    shifted = tbl >> (idx * iw);
    mask    = (c_TBL_MAX_W'(1) << iw) - c_TBL_MAX_W'(1);
    return c_ITEM_MAX_W'(shifted & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/knap_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knap_eval                                                            |
// | Combinational grader: sums value/weight of a selection and applies   |
// | the acceptance rule.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module knap_eval
  import knap_pkg::*;
#(
  parameter int N_ITEMS    = c_N_ITEMS,
  parameter int IW         = c_IW,
  parameter int SW         = c_SW,
  parameter int MIN_VALUE  = c_MIN_VALUE,
  parameter int MAX_WEIGHT = c_MAX_WEIGHT
)(
  input  logic [N_ITEMS-1:0]    i_sel,
  input  logic [N_ITEMS*IW-1:0] i_value_tbl,
  input  logic [N_ITEMS*IW-1:0] i_weight_tbl,
  output logic [SW-1:0]         o_value,
  output logic [SW-1:0]         o_weight,
  output logic                  o_accept
);

  logic [c_TBL_MAX_W-1:0] w_vtbl;
  logic [c_TBL_MAX_W-1:0] w_wtbl;

  assign w_vtbl = c_TBL_MAX_W'(i_value_tbl);
  assign w_wtbl = c_TBL_MAX_W'(i_weight_tbl);

  always_comb begin
    o_value  = '0;
    o_weight = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (i_sel[i]) begin
        o_value  = o_value  + SW'(get_item(w_vtbl, i, IW));
        o_weight = o_weight + SW'(get_item(w_wtbl, i, IW));
      end
    end
  end

  assign o_accept = (32'(o_value) > 32'(MIN_VALUE)) &&
                    (32'(o_weight) <= 32'(MAX_WEIGHT));

endmodule
`default_nettype wire

// File: rtl/knap_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knap_search                                                          |
// | Enumerates all 2^N_ITEMS selections, streams accepted ones on a      |
// | valid/ready port and tracks the best selection and solution count.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module knap_search
  import knap_pkg::*;
#(
  parameter int N_ITEMS    = c_N_ITEMS,
  parameter int IW         = c_IW,
  parameter int SW         = c_SW,
  parameter int MIN_VALUE  = c_MIN_VALUE,
  parameter int MAX_WEIGHT = c_MAX_WEIGHT
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_ITEMS*IW-1:0] item_value,
  input  logic [N_ITEMS*IW-1:0] item_weight,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_ITEMS-1:0]    out_sel,
  output logic [SW-1:0]         out_value,
  output logic [SW-1:0]         out_weight,
  output logic                  done,
  output logic [N_ITEMS:0]      sol_count,
  output logic                  best_valid,
  output logic [N_ITEMS-1:0]    best_sel,
  output logic [SW-1:0]         best_value
);

  knap_state_e           r_state;
  knap_state_e           w_state_nxt;
  logic [N_ITEMS-1:0]    r_cand;
  logic [N_ITEMS*IW-1:0] r_value_tbl;
  logic [N_ITEMS*IW-1:0] r_weight_tbl;
  logic                  r_out_valid;
  logic [N_ITEMS-1:0]    r_out_sel;
  logic [SW-1:0]         r_out_value;
  logic [SW-1:0]         r_out_weight;
  logic [N_ITEMS:0]      r_sol_count;
  logic                  r_best_valid;
  logic [N_ITEMS-1:0]    r_best_sel;
  logic [SW-1:0]         r_best_value;

  logic [SW-1:0] w_value;
  logic [SW-1:0] w_weight;
  logic          w_accept;
  logic          w_start_ok;
  logic          w_advance;
  logic          w_step;
  logic          w_last;

  knap_eval #(
    .N_ITEMS    (N_ITEMS),
    .IW         (IW),
    .SW         (SW),
    .MIN_VALUE  (MIN_VALUE),
    .MAX_WEIGHT (MAX_WEIGHT)
  ) u_eval (
    .i_sel        (r_cand),
    .i_value_tbl  (r_value_tbl),
    .i_weight_tbl (r_weight_tbl),
    .o_value      (w_value),
    .o_weight     (w_weight),
    .o_accept     (w_accept)
  );

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_advance  = !r_out_valid || out_ready;
  assign w_step     = (r_state == ST_SEARCH) && w_advance;
  assign w_last     = (r_cand == {N_ITEMS{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_state_nxt = ST_SEARCH;
      ST_SEARCH:        if (w_step && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:         if (w_advance) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand       <= '0;
      r_value_tbl  <= '0;
      r_weight_tbl <= '0;
      r_out_valid  <= 1'b0;
      r_out_sel    <= '0;
      r_out_value  <= '0;
      r_out_weight <= '0;
      r_sol_count  <= '0;
      r_best_valid <= 1'b0;
      r_best_sel   <= '0;
      r_best_value <= '0;
    end else if (w_start_ok) begin
      r_value_tbl  <= item_value;
      r_weight_tbl <= item_weight;
      r_cand       <= '0;
      r_sol_count  <= '0;
      r_best_valid <= 1'b0;
      r_best_sel   <= '0;
      r_best_value <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_step) begin
        if (w_accept) begin
          r_out_valid  <= 1'b1;
          r_out_sel    <= r_cand;
          r_out_value  <= w_value;
          r_out_weight <= w_weight;
          r_sol_count  <= r_sol_count + (N_ITEMS+1)'(1);
          // Strict compare: on a tie the earlier selection stays best.
          if (!r_best_valid || (w_value > r_best_value)) begin
            r_best_valid <= 1'b1;
            r_best_sel   <= r_cand;
            r_best_value <= w_value;
          end
        end
        if (!w_last) r_cand <= r_cand + N_ITEMS'(1);
      end
    end
  end

  assign busy       = (r_state == ST_SEARCH) || (r_state == ST_DRAIN);
  assign done       = (r_state == ST_DONE);
  assign out_valid  = r_out_valid;
  assign out_sel    = r_out_sel;
  assign out_value  = r_out_value;
  assign out_weight = r_out_weight;
  assign sol_count  = r_sol_count;
  assign best_valid = r_best_valid;
  assign best_sel   = r_best_sel;
  assign best_value = r_best_value;

endmodule
`default_nettype wire

// File: doc/knap_search.md
# knap_search

Sequential subset enumerator for the knapsack flow. It drives candidate selections one per cycle over all 2^N_ITEMS subsets and applies the value/weight acceptance rule to each. It streams every accepted selection out on a valid/ready port and reports the best selection and solution count at the end. It is the producer side of the combinational knapsack checker: the checker grades one selection, this block generates and grades all of them.

## Interface
- N_ITEMS, 5: number of items; selection bit i = item i (bit 0 = item A).
- IW, 4: width of each item value/weight.
- SW, 7: width of value/weight sums; must satisfy 2^SW > N_ITEMS*(2^IW-1).
- MIN_VALUE, 15: accept only if total value > MIN_VALUE (strict).
- MAX_WEIGHT, 16: accept only if total weight <= MAX_WEIGHT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; honoured only in IDLE or DONE.
- item_value  in  N_ITEMS*IW  item i value at [i*IW +: IW]; sampled on accepted start.
- item_weight  in  N_ITEMS*IW  item i weight, same packing; sampled on accepted start.
- busy  out  1  high in SEARCH and DRAIN.
- out_valid  out  1  accepted selection available.
- out_ready  in  1  consumer accepts out_* this cycle.
- out_sel  out  N_ITEMS  accepted selection.
- out_value  out  SW  its total value.
- out_weight  out  SW  its total weight.
- done  out  1  high in DONE until the next accepted start.
- sol_count  out  N_ITEMS+1  number of accepted selections in the last search.
- best_valid  out  1  at least one selection accepted.
- best_sel  out  N_ITEMS  selection with highest value.
- best_value  out  SW  that value.

## Operation
- States: IDLE, SEARCH, DRAIN, DONE.
- IDLE/DONE + start:
  - latch item tables;
  - cand=0, sol_count=0, best_*=0, done=0;
  - go to SEARCH.
- SEARCH: combinationally sum value and weight of the latched items selected by cand. All arithmetic is unsigned and zero-extended to SW. accept = (value > MIN_VALUE) && (weight <= MAX_WEIGHT).
- advance = !out_valid || out_ready. On an advance cycle:
  - if accept: load out_sel/out_value/out_weight and set out_valid;
  - if accept: sol_count += 1;
  - if accept and value > best_value (or best_valid=0): update best_*;
  - cand += 1.
  - Ties keep the earlier (lower-index) selection.
- No advance: cand holds and the candidate is re-evaluated next cycle. No candidate is skipped or duplicated.
- out_valid clears on an out_ready cycle unless a new accepted candidate loads in the same cycle.
- Last candidate (all ones) consumed on advance: go to DRAIN. cand does not wrap into a second pass.
- DRAIN: wait until !out_valid, or out_valid && out_ready, then go to DONE.
- DONE: outputs hold; start restarts the search. start during SEARCH/DRAIN is ignored.
- Reset (any time, including mid-search):
  - state=IDLE;
  - all outputs 0: busy, out_valid, out_sel, out_value, out_weight, done, sol_count, best_valid, best_sel, best_value;
  - cand=0 and item tables cleared.

## Timing
- First candidate is evaluated in the first SEARCH cycle, i.e. the cycle after start is sampled.
- Accepted result appears on out_* one cycle after its evaluation cycle.
- With out_ready tied high, throughput is one candidate per cycle. The full search takes 2^N_ITEMS SEARCH cycles plus 1 DRAIN cycle; done rises on the following edge.
- out_* must be stable while out_valid && !out_ready.
- sol_count and best_* are final when done=1. During the search they reflect candidates consumed so far.

## Structure
- Shared package knap_pkg holds the state enum and a function extracting item i from the packed tables.
- knap_pkg also holds the default thresholds MIN_VALUE/MAX_WEIGHT, shared with the combinational checker.
- One sub-module: knap_eval, combinational. It takes selection and tables and returns value, weight and accept. The same rule as the checker, parameterised.

## Test plan
- Values [4,2,2,1,10], weights [12,1,2,1,4], defaults, out_ready=1 -> no out_valid; done after 33 cycles; sol_count=0; best_valid=0.
- Same tables, MIN_VALUE=13 -> out_sel 17 (14,16), 22 (14,7), 30 (15,8), in that order; sol_count=3; best_sel=30; best_value=15.
- MIN_VALUE=13 case with out_ready low for 5 cycles at each out_valid -> same three results, out_* held stable, none lost or repeated; done delayed 15 cycles.
- All values 15, weights 0, MIN_VALUE=0 -> 31 results (sel 1..31); best_sel=31 (value 75 fits SW=7); tie rule not triggered.
- Values all 3, weights all 1, MIN_VALUE=2, MAX_WEIGHT=1 -> sel 1,2,4,8,16 accepted; best_sel=1 (tie keeps first).
- Assert rst_n mid-search with out_valid=1 -> all outputs 0 immediately. start after release -> full correct search from cand 0. start pulsed during SEARCH -> ignored.
